// File: rtl/irda_pkg.sv
// Shared types and default constants for the IrDA half-duplex link scheduler.
package irda_pkg;

    // Link ownership phases; TX_* own the transmitter, RX_* own the receiver.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_LOAD  = 3'd1,
        ST_TX_RUN   = 3'd2,
        ST_TX_GUARD = 3'd3,
        ST_RX_RUN   = 3'd4,
        ST_RX_GUARD = 3'd5
    } state_t;

    localparam int DATA_W_DEF     = 7;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int GUARD_CYC_DEF  = 1000;
    localparam int RX_TIMEOUT_DEF = 500000;
    localparam int CNT_W_DEF      = 20;

    // True while the transmitter is released from reset and enabled.
    function automatic logic is_tx_owner(input state_t s);
        return (s == ST_TX_LOAD) || (s == ST_TX_RUN);
    endfunction

endpackage

// File: rtl/irda_char_fifo.sv
// Small synchronous character queue; a push while full is still accepted
// when a pop happens in the same cycle, since a slot frees up at that edge.
module irda_char_fifo
    import irda_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Next pointer/count values; power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array kept free of reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/irda_link_scheduler.sv
// Half-duplex owner of the shared IR channel: queues key-entered characters,
// hands the link to either the transmitter or the receiver, enforces a guard
// gap after every frame, blanks our own echo and aborts stalled receptions.
module irda_link_scheduler
    import irda_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int GUARD_CYC  = GUARD_CYC_DEF,
    parameter int RX_TIMEOUT = RX_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send_key,
    input  logic [DATA_W-1:0]             data_txd,
    input  logic                          rxd_ir,
    input  logic                          trans_done,
    input  logic                          rcv_done,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          ena_trans,
    output logic                          start_trans,
    output logic                          rst_transmitter,
    output logic                          ena_rcv,
    output logic                          start_rcv,
    output logic                          rst_receiver,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_overflow,
    output logic                          rx_timeout,
    output logic                          busy
);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(RX_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              rxd_meta_q, rxd_sync_q, key_q;
    logic              tx_overflow_q, tx_overflow_d;
    logic              rx_timeout_q, rx_timeout_d;
    logic              ena_trans_q, ena_trans_d, start_trans_q, start_trans_d;
    logic              ena_rcv_q, ena_rcv_d, start_rcv_q, start_rcv_d;
    logic              busy_q, busy_d;
    logic              push_req, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    assign push_req = send_key && !key_q;
    assign fifo_pop = (state_q == ST_TX_LOAD);

    irda_char_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (data_txd),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ownership sequencing, guard/watchdog counting and next-state output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        rx_timeout_d  = 1'b0;
        tx_overflow_d = tx_overflow_q || (push_req && fifo_full && !fifo_pop);
        case (state_q)
            ST_IDLE: begin
                // Incoming light takes priority over pending transmissions.
                if (rxd_sync_q) begin
                    state_d = ST_RX_RUN;
                    cnt_d   = '0;
                end else if (!fifo_empty) begin
                    state_d = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                tx_data_d = fifo_rd_data;
                state_d   = ST_TX_RUN;
            end
            ST_TX_RUN: begin
                if (trans_done) begin
                    state_d = ST_TX_GUARD;
                    cnt_d   = '0;
                end
            end
            ST_TX_GUARD, ST_RX_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RX_RUN: begin
                if (rcv_done) begin
                    state_d = ST_RX_GUARD;
                    cnt_d   = '0;
                end else if (cnt_q == RX_LAST) begin
                    rx_timeout_d = 1'b1;
                    state_d      = ST_RX_GUARD;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        ena_trans_d   = is_tx_owner(state_d);
        start_trans_d = (state_q == ST_TX_LOAD);
        ena_rcv_d     = (state_d == ST_RX_RUN);
        start_rcv_d   = (state_d == ST_RX_RUN) && (state_q != ST_RX_RUN);
        busy_d        = (state_d != ST_IDLE);
    end

    // State, synchroniser, key edge history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            rxd_meta_q    <= 1'b0;
            rxd_sync_q    <= 1'b0;
            key_q         <= 1'b0;
            tx_overflow_q <= 1'b0;
            rx_timeout_q  <= 1'b0;
            ena_trans_q   <= 1'b0;
            start_trans_q <= 1'b0;
            ena_rcv_q     <= 1'b0;
            start_rcv_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            rxd_meta_q    <= rxd_ir;
            rxd_sync_q    <= rxd_meta_q;
            key_q         <= send_key;
            tx_overflow_q <= tx_overflow_d;
            rx_timeout_q  <= rx_timeout_d;
            ena_trans_q   <= ena_trans_d;
            start_trans_q <= start_trans_d;
            ena_rcv_q     <= ena_rcv_d;
            start_rcv_q   <= start_rcv_d;
            busy_q        <= busy_d;
        end
    end

    assign tx_data         = tx_data_q;
    assign ena_trans       = ena_trans_q;
    assign start_trans     = start_trans_q;
    assign rst_transmitter = !ena_trans_q;
    assign ena_rcv         = ena_rcv_q;
    assign start_rcv       = start_rcv_q;
    assign rst_receiver    = !ena_rcv_q;
    assign tx_overflow     = tx_overflow_q;
    assign rx_timeout      = rx_timeout_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_irda_link_scheduler.sv
// Randomised episodes against a transaction-level model of the scheduler:
// queued characters, sticky overflow, guard length, watchdog and link ownership.
module tb_irda_link_scheduler;
    localparam int DW    = 7;
    localparam int DEPTH = 4;
    localparam int GUARD = 20;
    localparam int RXTO  = 50;
    localparam int CNTW  = 20;

    logic clk = 1'b0;
    logic rst, send_key, rxd_ir, trans_done, rcv_done;
    logic [DW-1:0] data_txd, tx_data;
    logic ena_trans, start_trans, rst_transmitter, ena_rcv, start_rcv, rst_receiver;
    logic [2:0] fifo_count;
    logic tx_overflow, rx_timeout, busy;

    always #5 clk = ~clk;

    irda_link_scheduler #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GUARD_CYC(GUARD), .RX_TIMEOUT(RXTO), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .send_key(send_key), .data_txd(data_txd), .rxd_ir(rxd_ir),
        .trans_done(trans_done), .rcv_done(rcv_done), .tx_data(tx_data),
        .ena_trans(ena_trans), .start_trans(start_trans), .rst_transmitter(rst_transmitter),
        .ena_rcv(ena_rcv), .start_rcv(start_rcv), .rst_receiver(rst_receiver),
        .fifo_count(fifo_count), .tx_overflow(tx_overflow), .rx_timeout(rx_timeout), .busy(busy)
    );

    int tests = 0, fails = 0;
    int occ = 0;                 // characters the model believes are queued
    bit ovf_exp = 0;
    logic [DW-1:0] exp_tx[$];    // scoreboard: characters in expected send order
    logic [DW-1:0] mon_e;
    int rcv_starts = 0, timeouts = 0, exp_timeouts = 0, inv_bad = 0;
    bit prev_st = 0, prev_sr = 0, prev_to = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transmitter start and watches invariants.
    always @(negedge clk) begin
        if (rst) begin
            if (start_trans) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected_start", 1, 0);
                end else begin
                    mon_e = exp_tx.pop_front();
                    occ--;
                    chk("tx_data", int'(tx_data), int'(mon_e));
                    $display("[TB] tx frame: data=%02h expected=%02h", tx_data, mon_e);
                end
            end
            if (start_rcv) begin
                rcv_starts++;
                $display("[TB] rx frame start #%0d", rcv_starts);
            end
            if (rx_timeout) begin
                timeouts++;
                $display("[TB] rx watchdog abort #%0d", timeouts);
            end
            if (ena_trans && ena_rcv) inv_bad++;
            if (ena_trans == rst_transmitter) inv_bad++;
            if (ena_rcv == rst_receiver) inv_bad++;
            if (start_trans && prev_st) inv_bad++;
            if (start_rcv && prev_sr) inv_bad++;
            if (rx_timeout && prev_to) inv_bad++;
            prev_st = start_trans;
            prev_sr = start_rcv;
            prev_to = rx_timeout;
        end
    end

    // One key press; the model accepts it if a slot is free (or one frees at that edge).
    task automatic push_key(input logic [DW-1:0] c, input bit with_pop);
        data_txd = c;
        send_key = 1'b1;
        if (with_pop || occ < DEPTH) begin
            occ++;
            exp_tx.push_back(c);
            $display("[TB] push %02h accepted (queued=%0d)", c, occ);
        end else begin
            ovf_exp = 1'b1;
            $display("[TB] push %02h dropped (queue full)", c);
        end
        @(negedge clk);
        send_key = 1'b0;
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            push_key(DW'($urandom), 1'b0);
            @(negedge clk);
        end
    endtask

    // Called on the first guard cycle; guard must last exactly GUARD cycles.
    task automatic measure_guard();
        int n = 1;
        for (int i = 0; i < GUARD + 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("guard_len", n, GUARD);
        chk("idle_both_reset", int'({rst_transmitter, rst_receiver}), 3);
    endtask

    task automatic wait_start(output int kind, output int cyc);
        kind = 0;
        cyc  = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (start_trans) begin kind = 1; cyc = i; break; end
            if (start_rcv)   begin kind = 2; cyc = i; break; end
        end
        if (kind == 0) chk("start_wait_expired", 0, 1);
    endtask

    // Entered on the negedge showing start_trans.
    task automatic tx_session(input bit allow_push, input int n_force, input bit echo);
        int n;
        #1;
        chk("ena_trans_in_run", int'(ena_trans), 1);
        chk("fifo_count_at_start", int'(fifo_count), occ);
        if (allow_push) begin
            n = (n_force >= 0) ? n_force : int'($urandom_range(0, 5));
            push_burst(n);
            chk("fifo_count_after_push", int'(fifo_count), occ);
            chk("tx_overflow", int'(tx_overflow), int'(ovf_exp));
        end
        if (echo) rxd_ir = 1'b1;
        rcv_done = 1'b1;
        @(negedge clk);
        rcv_done = 1'b0;
        chk("rcv_done_ignored_in_tx", int'(ena_trans), 1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        chk("tx_released", int'({ena_trans, rst_transmitter}), 1);
        measure_guard();
    endtask

    // Entered on the negedge showing start_rcv.
    task automatic rx_session(input bit allow_push, input bit timeout);
        int j;
        #1;
        rxd_ir = 1'b0;
        chk("rcv_enabled", int'({ena_rcv, rst_receiver}), 2);
        if (timeout) begin
            j = 0;
            for (int i = 0; i < RXTO + 10; i++) begin
                @(negedge clk);
                j++;
                if (j == 3) trans_done = 1'b1;
                if (j == 4) trans_done = 1'b0;
                if (rx_timeout) break;
            end
            chk("rx_timeout_cycle", j, RXTO);
            chk("rx_released_on_timeout", int'({ena_rcv, rst_receiver}), 1);
            exp_timeouts++;
            measure_guard();
        end else begin
            if (allow_push) begin
                push_burst(int'($urandom_range(0, 5)));
                chk("fifo_count_in_rx", int'(fifo_count), occ);
                chk("tx_overflow_in_rx", int'(tx_overflow), int'(ovf_exp));
            end
            trans_done = 1'b1;
            @(negedge clk);
            trans_done = 1'b0;
            chk("trans_done_ignored_in_rx", int'(ena_rcv), 1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rcv_done = 1'b1;
            @(negedge clk);
            rcv_done = 1'b0;
            chk("rx_released", int'({ena_rcv, rst_receiver}), 1);
            measure_guard();
        end
    endtask

    // Sends every queued character; once, a full queue gets a push on the pop edge.
    task automatic drain();
        int kind, cyc;
        bit did_pp = 0;
        while (occ > 0) begin
            if (occ == DEPTH && !did_pp) begin
                did_pp = 1'b1;
                @(negedge clk);
                chk("tx_load_phase", int'({ena_trans, start_trans}), 2);
                push_key(DW'($urandom), 1'b1);
                chk("push_pop_start", int'(start_trans), 1);
            end else begin
                wait_start(kind, cyc);
                if (kind != 1) begin
                    chk("drain_expect_tx", kind, 1);
                    return;
                end
            end
            tx_session(1'b0, -1, 1'b0);
        end
    endtask

    task automatic episode_tx(input int n_force, input bit echo);
        int kind, cyc;
        push_key(DW'($urandom), 1'b0);
        wait_start(kind, cyc);
        chk("tx_first", kind, 1);
        chk("tx_latency", cyc, 2);
        if (kind != 1) return;
        tx_session(1'b1, n_force, echo);
        if (echo) begin
            wait_start(kind, cyc);
            chk("echo_rx_after_guard", kind, 2);
            chk("echo_rx_latency", cyc, 1);
            if (kind != 2) return;
            rx_session(1'b0, 1'b0);
        end
        drain();
    endtask

    task automatic episode_rx(input bit timeout);
        int kind, cyc;
        rxd_ir = 1'b1;
        @(negedge clk);
        push_key(DW'($urandom), 1'b0);
        wait_start(kind, cyc);
        chk("rx_wins", kind, 2);
        chk("rx_latency", cyc, 1);
        if (kind != 2) return;
        rx_session(1'b1, timeout);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_tx_side"}, int'({ena_trans, start_trans, rst_transmitter}), 1);
        chk({tag, "_rx_side"}, int'({ena_rcv, start_rcv, rst_receiver}), 1);
        chk({tag, "_fifo_count"}, int'(fifo_count), 0);
        chk({tag, "_flags"}, int'({tx_overflow, rx_timeout, busy}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of run, expected finish");
        $fatal(1);
    end

    initial begin
        int kind, cyc, base;
        rst = 1'b0; send_key = 1'b0; rxd_ir = 1'b0; trans_done = 1'b0; rcv_done = 1'b0;
        data_txd = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int ep = 0; ep < 12; ep++) begin
            case (ep)
                0: episode_tx(1, 1'b1);
                1: episode_rx(1'b1);
                2: episode_tx(5, 1'b0);
                3: episode_rx(1'b0);
                default: begin
                    if ($urandom_range(0, 1) == 0) episode_tx(-1, 1'($urandom_range(0, 1)));
                    else episode_rx(1'($urandom_range(0, 1)));
                end
            endcase
            repeat (2) @(negedge clk);
            chk("idle_between", int'({busy, fifo_count}), 0);
        end

        // Asynchronous reset in the middle of a transmission.
        push_key(DW'($urandom), 1'b0);
        wait_start(kind, cyc);
        #1;
        push_burst(2);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_tx.delete();
        occ = 0;
        ovf_exp = 1'b0;
        base = rcv_starts;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("after_reset_no_rx", rcv_starts, base);
        chk("after_reset_idle", int'({busy, fifo_count, tx_overflow}), 0);

        chk("timeout_pulses", timeouts, exp_timeouts);
        chk("invariants", inv_bad, 0);
        chk("scoreboard_empty", exp_tx.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
